mands_stats: RTL and testbench

Parametrised streaming statistics unit, the next generation of the MandS max/sum block. Over a framed stream of samples it accumulates running Max, Min, Sum and sample count, with signed/unsigned mode selection and saturating or wrapping sum overflow. It signals end of frame with a one-cycle `done` pulse and holds the results until the next frame starts. It sits directly behind the sample source, using the same start/valid stream protocol as MandS, plus an explicit `last` marker.

---
 rtl/mands_stats.sv | 142 ++++++++++++++
 tb/tb_mands_stats.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mands_stats.sv
// mands_stats: framed streaming Max/Min/Sum/Count unit.
// Frames open with start, close with valid & last.
// Signed or unsigned operation is chosen by SIGNED.
// Sum overflow saturates or wraps, chosen by SATURATE.
module mands_stats #(
  parameter int DATA_W   = 8,
  parameter int SUM_W    = 12,
  parameter int CNT_W    = 8,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic              valid,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] Max,
  output logic [DATA_W-1:0] Min,
  output logic [SUM_W-1:0]  Sum,
  output logic [CNT_W-1:0]  Cnt,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [SUM_W:0]      data_ext;
  logic [SUM_W:0]      sum_wide;
  logic                sum_over;

  // Sign- or zero-extend a sample to one bit wider than the sum.
  function automatic logic [SUM_W:0] ext_data(input logic [DATA_W-1:0] d);
    if (SIGNED != 0) return {{(SUM_W+1-DATA_W){d[DATA_W-1]}}, d};
    else             return {{(SUM_W+1-DATA_W){1'b0}}, d};
  endfunction

  // Extend the running sum by one guard bit in the selected mode.
  function automatic logic [SUM_W:0] ext_sum(input logic [SUM_W-1:0] s);
    if (SIGNED != 0) return {s[SUM_W-1], s};
    else             return {1'b0, s};
  endfunction

  // Mode-aware strict greater-than on samples.
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Clamp value for an overflowing sum; neg selects the lower rail.
  function automatic logic [SUM_W-1:0] sat_sum(input logic neg);
    if (SIGNED != 0) return neg ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    else             return {SUM_W{1'b1}};
  endfunction

  // Guard-bit addition; overflow when the guard bit disagrees with the result range.
  always_comb begin
    data_ext = ext_data(data);
    sum_wide = ext_sum(sum_q) + data_ext;
    if (SIGNED != 0) sum_over = sum_wide[SUM_W] ^ sum_wide[SUM_W-1];
    else             sum_over = sum_wide[SUM_W];
  end

  // Next-state and statistics update; start always clears and (re)opens a frame.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = ACC;
      max_d   = '0;
      min_d   = '0;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ACC: begin
          if (valid) begin
            if (cnt_q == '0) begin
              max_d = data;
              min_d = data;
              sum_d = data_ext[SUM_W-1:0];
            end else begin
              if (gt(data, max_q)) max_d = data;
              if (gt(min_q, data)) min_d = data;
              if (sum_over) begin
                ovf_d = 1'b1;
                sum_d = (SATURATE != 0) ? sat_sum(sum_wide[SUM_W]) : sum_wide[SUM_W-1:0];
              end else begin
                sum_d = sum_wide[SUM_W-1:0];
              end
            end
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
            if (last) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and statistics registers with asynchronous clear.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q <= IDLE;
      max_q   <= '0;
      min_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Max  = max_q;
  assign Min  = min_q;
  assign Sum  = sum_q;
  assign Cnt  = cnt_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == ACC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mands_stats.sv
// Directed bench for mands_stats: defaults, unsigned and wrapping instances share one stimulus.
module tb_mands_stats;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       start = 1'b0, valid = 1'b0, last = 1'b0;
  logic [7:0] data = 8'h00;

  logic [7:0]  d_max, d_min, u_max, u_min, w_max, w_min;
  logic [11:0] d_sum, u_sum, w_sum;
  logic [7:0]  d_cnt, u_cnt, w_cnt;
  logic        d_busy, d_done, d_ovf, u_busy, u_done, u_ovf, w_busy, w_done, w_ovf;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mands_stats u_def (
    .clk(clk), .resetb(resetb), .start(start), .valid(valid), .last(last), .data(data),
    .Max(d_max), .Min(d_min), .Sum(d_sum), .Cnt(d_cnt), .busy(d_busy), .done(d_done), .ovf(d_ovf));

  mands_stats #(.SIGNED(0)) u_uns (
    .clk(clk), .resetb(resetb), .start(start), .valid(valid), .last(last), .data(data),
    .Max(u_max), .Min(u_min), .Sum(u_sum), .Cnt(u_cnt), .busy(u_busy), .done(u_done), .ovf(u_ovf));

  mands_stats #(.SATURATE(0)) u_wrap (
    .clk(clk), .resetb(resetb), .start(start), .valid(valid), .last(last), .data(data),
    .Max(w_max), .Min(w_min), .Sum(w_sum), .Cnt(w_cnt), .busy(w_busy), .done(w_done), .ovf(w_ovf));

  // Count done pulses of the default instance, sampled away from the rising edge.
  always @(negedge clk) if (d_done) done_cnt++;

  // Apply one cycle of inputs right after a falling edge.
  task automatic drive(input logic s, input logic v, input logic l, input logic [7:0] d);
    @(negedge clk);
    start = s; valid = v; last = l; data = d;
  endtask

  task automatic test_reset();
    logic [47:0] all_d, all_u, all_w;
    repeat (2) @(negedge clk);
    all_d = {d_max, d_min, d_sum, d_cnt, d_busy, d_done, d_ovf, 5'b0};
    all_u = {u_max, u_min, u_sum, u_cnt, u_busy, u_done, u_ovf, 5'b0};
    all_w = {w_max, w_min, w_sum, w_cnt, w_busy, w_done, w_ovf, 5'b0};
    n_chk++; if (all_d !== 48'h0) begin n_fail++; $display("FAIL reset_def got %h want 0", all_d); end
    n_chk++; if (all_u !== 48'h0) begin n_fail++; $display("FAIL reset_uns got %h want 0", all_u); end
    n_chk++; if (all_w !== 48'h0) begin n_fail++; $display("FAIL reset_wrap got %h want 0", all_w); end
    resetb = 1'b0;
    drive(0, 1, 1, 8'h11);  // valid in IDLE is ignored
    drive(0, 0, 0, 8'h00);
    n_chk++; if ({d_busy, d_cnt} !== 9'h0) begin n_fail++; $display("FAIL idle_valid got %h want 0", {d_busy, d_cnt}); end
  endtask

  task automatic test_basic();
    int dc0;
    logic [7:0] s [9] = '{8'hFB, 8'hFE, 8'h03, 8'h01, 8'h07, 8'h00, 8'h01, 8'hFB, 8'h03};
    dc0 = done_cnt;
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, i == 8, s[i]);
      if (i == 1) begin
        n_chk++;
        if ({d_busy, d_max, d_min, d_sum, d_cnt} !== {1'b1, 8'hFB, 8'hFB, 12'hFFB, 8'd1}) begin
          n_fail++; $display("FAIL basic_first got %h want %h", {d_busy, d_max, d_min, d_sum, d_cnt}, {1'b1, 8'hFB, 8'hFB, 12'hFFB, 8'd1});
        end
      end
    end
    drive(0, 0, 0, 8'h00);
    n_chk++; if ({d_done, d_busy} !== 2'b10) begin n_fail++; $display("FAIL basic_done got %b want 10", {d_done, d_busy}); end
    n_chk++;
    if ({d_max, d_min, d_sum, d_cnt, d_ovf} !== {8'h07, 8'hFB, 12'h003, 8'd9, 1'b0}) begin
      n_fail++; $display("FAIL basic_final got %h want %h", {d_max, d_min, d_sum, d_cnt, d_ovf}, {8'h07, 8'hFB, 12'h003, 8'd9, 1'b0});
    end
    repeat (3) drive(0, 0, 0, 8'h00);
    n_chk++;
    if ({d_done, d_max, d_min, d_sum, d_cnt} !== {1'b0, 8'h07, 8'hFB, 12'h003, 8'd9}) begin
      n_fail++; $display("FAIL basic_hold got %h want %h", {d_done, d_max, d_min, d_sum, d_cnt}, {1'b0, 8'h07, 8'hFB, 12'h003, 8'd9});
    end
    n_chk++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt - dc0); end
  endtask

  // Second frame, also the unsigned vectors; the next frame starts in the DONE cycle.
  task automatic test_back_to_back();
    drive(1, 0, 0, 8'h00);
    drive(0, 1, 0, 8'hFF);
    drive(0, 1, 0, 8'h05);
    drive(0, 1, 1, 8'hE9);
    drive(1, 0, 0, 8'h00);  // start during DONE
    n_chk++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", d_done); end
    n_chk++;
    if ({d_max, d_min, d_sum, d_cnt} !== {8'h05, 8'hE9, 12'hFED, 8'd3}) begin
      n_fail++; $display("FAIL signed_final got %h want %h", {d_max, d_min, d_sum, d_cnt}, {8'h05, 8'hE9, 12'hFED, 8'd3});
    end
    n_chk++;
    if ({u_max, u_min, u_sum, u_cnt, u_ovf} !== {8'hFF, 8'h05, 12'd493, 8'd3, 1'b0}) begin
      n_fail++; $display("FAIL unsigned_final got %h want %h", {u_max, u_min, u_sum, u_cnt, u_ovf}, {8'hFF, 8'h05, 12'd493, 8'd3, 1'b0});
    end
    drive(0, 0, 0, 8'h00);
    n_chk++;
    if ({d_done, d_busy, d_sum, d_cnt, d_max} !== {1'b0, 1'b1, 12'h0, 8'd0, 8'h0}) begin
      n_fail++; $display("FAIL b2b_cleared got %h want %h", {d_done, d_busy, d_sum, d_cnt, d_max}, {1'b0, 1'b1, 12'h0, 8'd0, 8'h0});
    end
  endtask

  // Frame already open from the previous task: 17 x 127.
  task automatic test_saturate();
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, i == 16, 8'h7F);
      if (i == 16) begin
        n_chk++;
        if ({d_sum, d_ovf} !== {12'h7F0, 1'b0}) begin n_fail++; $display("FAIL sat_pre got %h want %h", {d_sum, d_ovf}, {12'h7F0, 1'b0}); end
      end
    end
    drive(0, 0, 0, 8'h00);
    n_chk++;
    if ({d_done, d_sum, d_ovf, d_cnt} !== {1'b1, 12'h7FF, 1'b1, 8'd17}) begin
      n_fail++; $display("FAIL sat_final got %h want %h", {d_done, d_sum, d_ovf, d_cnt}, {1'b1, 12'h7FF, 1'b1, 8'd17});
    end
    n_chk++;
    if ({w_sum, w_ovf, w_cnt} !== {12'h86F, 1'b1, 8'd17}) begin
      n_fail++; $display("FAIL wrap_final got %h want %h", {w_sum, w_ovf, w_cnt}, {12'h86F, 1'b1, 8'd17});
    end
  endtask

  task automatic test_cnt_hold();
    drive(0, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, i == 255, 8'h01);
      if (i == 255) begin
        n_chk++;
        if ({d_cnt, d_ovf} !== {8'hFF, 1'b0}) begin n_fail++; $display("FAIL cnt_full got %h want %h", {d_cnt, d_ovf}, {8'hFF, 1'b0}); end
      end
    end
    drive(0, 0, 0, 8'h00);
    n_chk++;
    if ({d_done, d_cnt, d_ovf, d_sum, d_max} !== {1'b1, 8'hFF, 1'b1, 12'h100, 8'h01}) begin
      n_fail++; $display("FAIL cnt_hold got %h want %h", {d_done, d_cnt, d_ovf, d_sum, d_max}, {1'b1, 8'hFF, 1'b1, 12'h100, 8'h01});
    end
  endtask

  task automatic test_abort();
    int dc0;
    drive(0, 0, 0, 8'h00);
    dc0 = done_cnt;
    drive(1, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h09);
    drive(0, 1, 0, 8'h04);
    drive(1, 1, 1, 8'h06);  // start wins over valid & last
    n_chk++; if (d_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_pre got %0d want 2", d_cnt); end
    drive(0, 1, 1, 8'h02);
    n_chk++;
    if ({d_done, d_busy, d_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL abort_clear got %h want %h", {d_done, d_busy, d_cnt}, {1'b0, 1'b1, 8'd0});
    end
    drive(0, 0, 0, 8'h00);
    n_chk++;
    if ({d_done, d_max, d_min, d_sum, d_cnt} !== {1'b1, 8'h02, 8'h02, 12'h002, 8'd1}) begin
      n_fail++; $display("FAIL abort_restart got %h want %h", {d_done, d_max, d_min, d_sum, d_cnt}, {1'b1, 8'h02, 8'h02, 12'h002, 8'd1});
    end
    drive(0, 0, 0, 8'h00);
    n_chk++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL abort_done_count got %0d want 1", done_cnt - dc0); end
  endtask

  task automatic test_mid_reset();
    int dc0;
    dc0 = done_cnt;
    drive(1, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h01);
    drive(0, 1, 0, 8'h02);
    drive(0, 1, 0, 8'h03);
    #1 resetb = 1'b1;
    #1;
    n_chk++;
    if ({d_max, d_min, d_sum, d_cnt, d_busy, d_done, d_ovf} !== 39'h0) begin
      n_fail++; $display("FAIL midreset_async got %h want 0", {d_max, d_min, d_sum, d_cnt, d_busy, d_done, d_ovf});
    end
    drive(0, 1, 1, 8'h04);
    drive(0, 0, 0, 8'h00);
    resetb = 1'b0;
    drive(0, 1, 1, 8'h55);
    repeat (3) drive(0, 0, 0, 8'h00);
    n_chk++;
    if ({d_busy, d_cnt, d_max, d_sum} !== 29'h0) begin
      n_fail++; $display("FAIL midreset_idle got %h want 0", {d_busy, d_cnt, d_max, d_sum});
    end
    n_chk++; if (done_cnt !== dc0) begin n_fail++; $display("FAIL midreset_no_done got %0d want %0d", done_cnt, dc0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_cnt_hold();
    test_abort();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
